// File: rtl/rf_bist_pkg.sv
// Shared types and constants for the register-file BIST initiator.
// The optional first-mismatch log is enabled with RF_BIST_ERRLOG_EN.
package rf_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    X0W,
    X0R,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam int          X0_ADDR    = 0;
  localparam logic [31:0] X0_PATTERN = 32'hFFFF_FFFF;
  localparam int          ERR_CNT_W  = 6;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Adds 0..2 mismatches to the running count, pinning at the maximum.
  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] cnt,
                                                   input logic [1:0]           inc);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
    return sum[ERR_CNT_W] ? ERR_CNT_MAX : sum[ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rf_bist_lfsr.sv
// Galois right-shift LFSR with synchronous load and advance; exposes both the
// current value and the value it will hold after the next edge.
module rf_bist_lfsr
  import rf_bist_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] SEED = 32'hACE1_2345,
  parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         adv_i,
  output logic [W-1:0] value_o,
  output logic [W-1:0] value_d_o
);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    value_d_o = value_o;
    if (load_i) begin
      value_d_o = SEED;
    end else if (adv_i) begin
      value_d_o = (value_o >> 1) ^ (value_o[0] ? TAPS : '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_o <= SEED;
    end else begin
      value_o <= value_d_o;
    end
  end

endmodule

// File: rtl/rf_bist.sv
// BIST initiator for a 32x32 register file: LFSR fill of x1..x31, dual-port
// read-back compare, and an x0 write/read check. Optional log: RF_BIST_ERRLOG_EN.
module rf_bist
  import rf_bist_pkg::*;
#(
  parameter int                ADDR_W = 5,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] SEED   = 32'hACE1_2345
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 rf_we_o,
  output logic [ADDR_W-1:0]    rf_adr3_o,
  output logic [DATA_W-1:0]    rf_wd3_o,
  output logic [ADDR_W-1:0]    rf_adr1_o,
  input  logic [DATA_W-1:0]    rf_rd1_i,
  output logic [ADDR_W-1:0]    rf_adr2_o,
  input  logic [DATA_W-1:0]    rf_rd2_i
`ifdef RF_BIST_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0]    err_adr_o,
  output logic                 err_port_o,
  output logic [DATA_W-1:0]    err_data_o
`endif
);

  localparam logic [ADDR_W-1:0] FIRST_ADR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADR  = '1;
  localparam logic [ADDR_W-1:0] X0_ADR    = ADDR_W'(X0_ADDR);
  localparam logic [DATA_W-1:0] X0_DATA   = DATA_W'(X0_PATTERN);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic                 start_acc;
  logic                 lfsr_load, lfsr_adv;
  logic [DATA_W-1:0]    lfsr_q, lfsr_d;
  logic                 mis1, mis2;
  logic [ERR_CNT_W-1:0] err_d;

  rf_bist_lfsr #(
    .W    (DATA_W),
    .SEED (SEED),
    .TAPS (DATA_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (lfsr_load),
    .adv_i     (lfsr_adv),
    .value_o   (lfsr_q),
    .value_d_o (lfsr_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The LFSR is rewound to SEED on the WR->RD edge so the read sweep sees the same sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_acc = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = WR;
          cnt_d     = FIRST_ADR;
          lfsr_load = 1'b1;
        end
      end
      WR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADR) begin
          state_d   = RD;
          cnt_d     = FIRST_ADR;
          lfsr_load = 1'b1;
        end else begin
          lfsr_adv = 1'b1;
        end
      end
      RD: begin
        cnt_d    = cnt_q + 1'b1;
        lfsr_adv = 1'b1;
        if (cnt_q == LAST_ADR) begin
          state_d = X0W;
        end
      end
      X0W:     state_d = X0R;
      X0R:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is compared in the cycle its address is presented on the ports.
  always_comb begin
    mis1 = 1'b0;
    mis2 = 1'b0;
    if (state_q == RD) begin
      mis1 = (rf_rd1_i != lfsr_q);
      mis2 = (rf_rd2_i != lfsr_q);
    end else if (state_q == X0R) begin
      mis1 = (rf_rd1_i != '0);
      mis2 = (rf_rd2_i != '0);
    end
    err_d = start_acc ? '0 : sat_add(err_cnt_o, {1'b0, mis1} + {1'b0, mis2});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      err_cnt_o <= '0;
      rf_we_o   <= 1'b0;
      rf_adr3_o <= '0;
      rf_wd3_o  <= '0;
      rf_adr1_o <= '0;
      rf_adr2_o <= '0;
    end else begin
      busy_o    <= (state_d == WR) || (state_d == RD) || (state_d == X0W) || (state_d == X0R);
      done_o    <= (state_d == DONE);
      pass_o    <= (state_d == DONE) && (err_d == '0);
      err_cnt_o <= err_d;
      rf_we_o   <= (state_d == WR) || (state_d == X0W);
      rf_adr3_o <= (state_d == WR)  ? cnt_d  :
                   (state_d == X0W) ? X0_ADR : '0;
      rf_wd3_o  <= (state_d == WR)  ? lfsr_d  :
                   (state_d == X0W) ? X0_DATA : '0;
      rf_adr1_o <= (state_d == RD)  ? cnt_d  :
                   (state_d == X0R) ? X0_ADR : '0;
      rf_adr2_o <= (state_d == RD)  ? cnt_d  :
                   (state_d == X0R) ? X0_ADR : '0;
    end
  end

`ifdef RF_BIST_ERRLOG_EN
  // A zero count means no mismatch yet this run; port 1 wins a same-cycle tie.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      err_adr_o  <= '0;
      err_port_o <= 1'b0;
      err_data_o <= '0;
    end else if ((err_cnt_o == '0) && (mis1 || mis2)) begin
      err_adr_o  <= rf_adr1_o;
      err_port_o <= !mis1;
      err_data_o <= mis1 ? rf_rd1_i : rf_rd2_i;
    end
  end
`endif

endmodule

// File: tb/tb_rf_bist.sv
// Self-checking bench for rf_bist: behavioural RF model with injectable read
// faults, directed scenarios plus randomized fault sets.
module tb_rf_bist;

  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        busy, done, pass;
  logic [5:0]  err_cnt;
  logic        rf_we;
  logic [4:0]  rf_adr3, rf_adr1, rf_adr2;
  logic [31:0] rf_wd3, rf_rd1, rf_rd2;
`ifdef RF_BIST_ERRLOG_EN
  logic [4:0]  err_adr;
  logic        err_port;
  logic [31:0] err_data;
`endif

  logic [31:0] mem   [32];
  logic [31:0] flip1 [32];
  logic [31:0] flip2 [32];
  bit          x0_writable = 1'b0;
  logic [31:0] pat   [32];

  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  exp_err;
  logic [4:0]  exp_adr;
  logic        exp_port;
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  rf_bist dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass),
    .err_cnt_o (err_cnt),
    .rf_we_o   (rf_we),
    .rf_adr3_o (rf_adr3),
    .rf_wd3_o  (rf_wd3),
    .rf_adr1_o (rf_adr1),
    .rf_rd1_i  (rf_rd1),
    .rf_adr2_o (rf_adr2),
    .rf_rd2_i  (rf_rd2)
`ifdef RF_BIST_ERRLOG_EN
    ,
    .err_adr_o  (err_adr),
    .err_port_o (err_port),
    .err_data_o (err_data)
`endif
  );

  // Register file model: write on the rising edge, combinational reads with faults.
  always @(posedge clk) begin
    if (rf_we) mem[rf_adr3] <= rf_wd3;
  end

  always_comb begin
    rf_rd1 = ((rf_adr1 == 5'd0 && !x0_writable) ? 32'h0 : mem[rf_adr1]) ^ flip1[rf_adr1];
    rf_rd2 = ((rf_adr2 == 5'd0 && !x0_writable) ? 32'h0 : mem[rf_adr2]) ^ flip2[rf_adr2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 32; a++) begin
      flip1[a] = 32'h0;
      flip2[a] = 32'h0;
    end
    x0_writable = 1'b0;
  endtask

  // Expected result from the fault set: every (address, port) whose read differs
  // from what was written counts once; x0 must always read zero.
  task automatic predict();
    logic [31:0] rd;
    int cnt;
    cnt = 0;
    exp_adr = '0; exp_port = 1'b0; exp_data = '0;
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] want;
        logic [31:0] stored;
        int ai;
        ai = (a + 1) % 32;
        want   = (ai == 0) ? 32'h0 : pat[ai];
        stored = (ai == 0) ? (x0_writable ? 32'hFFFF_FFFF : 32'h0) : pat[ai];
        rd = stored ^ ((p == 0) ? flip1[ai] : flip2[ai]);
        if (rd != want) begin
          if (cnt == 0) begin
            exp_adr  = 5'(ai);
            exp_port = (p == 1);
            exp_data = rd;
          end
          cnt++;
        end
      end
    end
    exp_err = (cnt > 63) ? 6'd63 : 6'(cnt);
  endtask

  // One start pulse, then step edge by edge; optional re-pulse or abort edge.
  task automatic run(input string tag, input int repulse_at, input int abort_at);
    predict();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int e = 0; e <= 64; e++) begin
      if (e == abort_at) begin
        check({tag, "_abort_we"},   rf_we, 0);
        check({tag, "_abort_busy"}, busy,  0);
        check({tag, "_abort_done"}, done,  0);
        rst_i = 1'b0;
        return;
      end
      if (e == 0) check({tag, "_busy"}, busy, 1);
      if (e <= 30) begin
        check({tag, "_wr_we"},   rf_we,   1);
        check({tag, "_wr_adr"},  rf_adr3, 64'(e + 1));
        check({tag, "_wr_data"}, rf_wd3,  pat[e + 1]);
      end
      if (e == 31) begin
        check({tag, "_rd_we"},   rf_we,   0);
        check({tag, "_rd_adr1"}, rf_adr1, 1);
        check({tag, "_rd_adr2"}, rf_adr2, 1);
      end
      if (e == 62) begin
        check({tag, "_x0w_adr"},  rf_adr3, 0);
        check({tag, "_x0w_data"}, rf_wd3,  32'hFFFF_FFFF);
      end
      if (e == 63) check({tag, "_done_early"}, done, 0);
      if (e == 64) begin
        check({tag, "_done"},    done,    1);
        check({tag, "_idle"},    busy,    0);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_pass"},    pass,    exp_err == 0);
`ifdef RF_BIST_ERRLOG_EN
        check({tag, "_log_adr"},  err_adr,  exp_adr);
        check({tag, "_log_port"}, err_port, exp_port);
        check({tag, "_log_data"}, err_data, exp_data);
`endif
      end
      if (e < 64) begin
        if (e + 1 == repulse_at) start_i = 1'b1;
        if (e + 1 == abort_at)   rst_i   = 1'b1;
        tick();
        start_i = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    v = SEED;
    pat[0] = 32'h0;
    for (int a = 1; a < 32; a++) begin
      pat[a] = v;
      v = (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    end
    clear_faults();

    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_pass",    pass,    0);
    check("rst_err",     err_cnt, 0);
    check("rst_we",      rf_we,   0);
    check("rst_adr3",    rf_adr3, 0);
    check("rst_wd3",     rf_wd3,  0);
    check("rst_adr1",    rf_adr1, 0);
`ifdef RF_BIST_ERRLOG_EN
    check("rst_log_adr", err_adr, 0);
`endif
    tick();

    run("clean", -1, -1);

    flip1[12] = 32'h1;
    run("rd1_bit0_a12", -1, -1);
    clear_faults();

    x0_writable = 1'b1;
    run("x0_stored", -1, -1);
    clear_faults();

    run("restart_ignored", 20, -1);
    run("rerun_from_done", -1, -1);

    run("abort_at_40", -1, 40);
    run("after_abort", -1, -1);

    for (int a = 0; a < 32; a++) begin
      flip1[a] = 32'hFFFF_FFFF;
      flip2[a] = 32'hFFFF_FFFF;
    end
    run("saturate", -1, -1);
    clear_faults();

    for (int it = 0; it < 4; it++) begin
      int nf;
      nf = $urandom_range(0, 4);
      for (int k = 0; k < nf; k++) begin
        int a;
        a = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 0) flip1[a] = $urandom();
        else                           flip2[a] = $urandom();
      end
      x0_writable = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 5)) tick();
      run("random", -1, -1);
      clear_faults();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
